// File: rtl/seq_alu.sv
// Registered ALU with a valid/ready input handshake and a multi-cycle shift-add multiplier.
// Single-cycle ops respond on the accept edge; MUL returns after WIDTH iterations.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_LSL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t               state_q, state_d;
    logic                 accept;
    logic                 mul_done;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH:0]     acc_add;
    logic [2*WIDTH:0]     acc_next;
    logic [WIDTH:0]       mul_sum;

    logic [WIDTH-1:0]     opb;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ov;

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        mul_done = 1'b0;
        case (state_q)
            IDLE: begin
                accept = in_valid;
                if (in_valid && op == OP_MUL) state_d = MUL_RUN;
            end
            MUL_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arithmetic ops share one adder: ADD/SUB/INC/DEC differ only in the second operand and carry-in.
    always_comb begin
        opb = '0;
        cin = 1'b0;
        case (op)
            OP_ADD:  opb = b;
            OP_SUB:  begin opb = ~b; cin = 1'b1; end
            OP_INC:  cin = 1'b1;
            OP_DEC:  opb = '1;
            default: opb = '0;
        endcase
        sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ov    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ov    = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ASR: begin
                alu_res   = {a[WIDTH-1], a[WIDTH-1:1]};
                alu_carry = a[0];
            end
            OP_LSL: begin
                alu_res   = {a[WIDTH-2:0], 1'b0};
                alu_carry = a[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end

    // acc holds {carry, product-high, multiplier}; each step adds then shifts the whole thing right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_add  = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : acc;
        acc_next = {1'b0, acc_add[2*WIDTH:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand <= a;
                    acc   <= {1'b0, {WIDTH{1'b0}}, b};
                    cnt   <= '0;
                end else begin
                    out_valid <= 1'b1;
                    result    <= alu_res;
                    result_hi <= '0;
                    carry     <= alu_carry;
                    zero      <= (alu_res == '0);
                    negative  <= alu_res[WIDTH-1];
                    overflow  <= alu_ov;
                end
            end
            if (state_q == MUL_RUN) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
                if (mul_done) begin
                    out_valid <= 1'b1;
                    result    <= acc_next[WIDTH-1:0];
                    result_hi <= acc_next[2*WIDTH-1:WIDTH];
                    carry     <= 1'b0;
                    zero      <= (acc_next[2*WIDTH-1:0] == '0);
                    negative  <= acc_next[2*WIDTH-1];
                    overflow  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH=4 with hand-computed expected values.
module tb_seq_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [W-1:0] er, input logic [W-1:0] eh,
                            input logic ec, input logic ez, input logic en, input logic ev);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".res"},   32'(result),    32'(er));
        checkOutput({tag, ".hi"},    32'(result_hi), 32'(eh));
        checkOutput({tag, ".c"},     32'(carry),     32'(ec));
        checkOutput({tag, ".z"},     32'(zero),      32'(ez));
        checkOutput({tag, ".n"},     32'(negative),  32'(en));
        checkOutput({tag, ".v"},     32'(overflow),  32'(ev));
    endtask

    // Present one transaction, let it be accepted at the next rising edge, sample 1ns later.
    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 4'd0;
        a        = '0;
        b        = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.ready", 32'(in_ready), 32'd1);
        checkOutput("rst.valid", 32'(out_valid), 32'd0);
        checkOutput("rst.res", 32'(result), 32'd0);
        checkOutput("rst.flags", 32'({carry, zero, negative, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'd0, 4'b1001, 4'b0101);
        checkAll("add", 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("idle.valid", 32'(out_valid), 32'd0);
        checkOutput("idle.hold", 32'(result), 32'hE);

        applyStimulus(4'd1, 4'b1001, 4'b0101);
        checkAll("sub", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd1, 4'b0011, 4'b0101);
        checkAll("sub_borrow", 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'd3, 4'b0000, 4'b0000);
        checkAll("dec0", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'd3, 4'b1000, 4'b0000);
        checkAll("dec_ov", 4'b0111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd2, 4'b0111, 4'b0000);
        checkAll("inc_ov", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'd2, 4'b1111, 4'b0000);
        checkAll("inc_wrap", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd7, 4'b1001, 4'b0000);
        checkAll("asr", 4'b1100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'd8, 4'b1001, 4'b0000);
        checkAll("lsl", 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd4, 4'b1100, 4'b1010);
        checkAll("and", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'd5, 4'b1100, 4'b0010);
        checkAll("or", 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'd12, 4'b1111, 4'b1111);
        checkAll("rsvd", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back single-cycle ops give consecutive pulses.
        applyStimulus(4'd0, 4'b1111, 4'b0001);
        checkAll("b2b_add", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd6, 4'b0110, 4'b0110);
        checkAll("b2b_xor", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // MUL 15*15 = 225; operands changed mid-run must be ignored.
        applyStimulus(4'd9, 4'b1111, 4'b1111);
        op = 4'd0; a = 4'b0001; b = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("mul_busy%0d.ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("mul_busy%0d.valid", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("mul_ff.ready", 32'(in_ready), 32'd1);
        checkAll("mul_ff", 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b1);

        // MUL 3*2 with in_valid held; the next ADD is only taken in the out_valid cycle.
        applyStimulus(4'd9, 4'b0011, 4'b0010);
        in_valid = 1'b1; op = 4'd0; a = 4'b0001; b = 4'b0001;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("mul_latency", 32'(cyc), 32'd4);
        checkAll("mul_32", 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkAll("held_add", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'd9, 4'b0000, 4'b0111);
        repeat (4) @(posedge clk);
        #1;
        checkAll("mul_zero", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        applyStimulus(4'd0, 4'b0001, 4'b0001);
        checkAll("pre_rst_add", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset two cycles into a MUL aborts it with no pulse.
        applyStimulus(4'd9, 4'b1111, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.res", 32'(result), 32'd0);
        checkOutput("abort.hi", 32'(result_hi), 32'd0);
        checkOutput("abort.valid", 32'(out_valid), 32'd0);
        checkOutput("abort.ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        checkOutput("abort.pulses", 32'(pulses), 32'd0);

        applyStimulus(4'd0, 4'b0111, 4'b0001);
        checkAll("post_rst_add", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
